// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, state encoding and instruction field layout
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam int INSTR_W = 9;
  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS1_MSB = 3;
  localparam int RS1_LSB = 2;
  localparam int RS2_MSB = 1;
  localparam int RS2_LSB = 0;

  function automatic logic writes_rd(input logic [2:0] op);
    return op != OP_CMP;
  endfunction

  function automatic logic updates_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - general register file, two operand read ports, one write port, debug read
module alu_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int REG_CNT = 4,
  parameter int AW      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [AW-1:0]     dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [REG_CNT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_sel];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - three-phase issue/writeback sequencer around an external ALU
module alu_issue_ctrl
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int REG_CNT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [8:0]        instr_data,
  input  logic              ld_en,
  input  logic [1:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_ci,
  input  logic [DATA_W-1:0] alu_fin,
  input  logic              alu_co,
  input  logic              alu_cf,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_gt,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state, state_nxt;
  logic [1:0]        lat_rd;
  logic              accept, wb_fire;
  logic              rf_we;
  logic [1:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata, rd_a, rd_b;

  wire [2:0] f_opc = instr_data[OPC_MSB:OPC_LSB];
  wire [1:0] f_rd  = instr_data[RD_MSB:RD_LSB];
  wire [1:0] f_rs1 = instr_data[RS1_MSB:RS1_LSB];
  wire [1:0] f_rs2 = instr_data[RS2_MSB:RS2_LSB];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (instr_valid && !ld_en) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Gating with rst_n keeps ready low while reset is being applied.
  assign instr_ready = rst_n && (state == ST_IDLE) && !ld_en;
  assign accept      = (state == ST_IDLE) && instr_valid && !ld_en;
  assign wb_fire     = (state == ST_EXEC);

  // Loads only happen in IDLE and writeback only on EXEC->WB, so the port never collides.
  assign rf_we    = ((state == ST_IDLE) && ld_en) || (wb_fire && writes_rd(alu_op));
  assign rf_waddr = wb_fire ? lat_rd  : ld_addr;
  assign rf_wdata = wb_fire ? alu_fin : ld_data;

  alu_regfile #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .AW(2)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .raddr_a  (f_rs1),
    .rdata_a  (rd_a),
    .raddr_b  (f_rs2),
    .rdata_b  (rd_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      alu_ci  <= 1'b0;
      lat_rd  <= '0;
      result  <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_gt <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= wb_fire;
      if (accept) begin
        alu_a  <= rd_a;
        alu_b  <= rd_b;
        alu_op <= f_opc;
        alu_ci <= (f_opc == OP_SUB);
        lat_rd <= f_rd;
      end
      if (wb_fire) begin
        flag_gt <= alu_cf;
        if (writes_rd(alu_op)) begin
          result <= alu_fin;
          flag_z <= (alu_fin == '0);
        end
        if (updates_carry(alu_op)) flag_c <= alu_co;
      end
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width; only 8 is supported.
REQ-002 SHALL have parameter REG_CNT, default 4, number of general registers; only 4 is supported.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port instr_valid  in  1  instruction offered.
REQ-007 SHALL have port instr_ready  out  1  instruction accepted this cycle when high with instr_valid.
REQ-008 SHALL have port instr_data  in  9  [8:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2.
REQ-009 SHALL have port ld_en  in  1  direct register load strobe.
REQ-010 SHALL have port ld_addr  in  2  load target register.
REQ-011 SHALL have port ld_data  in  8  load value.
REQ-012 SHALL have ports alu_a, alu_b  out  8 each  operands to the downstream ALU.
REQ-013 SHALL have port alu_op  out  3  ALU opcode.
REQ-014 SHALL have port alu_ci  out  1  ALU carry-in.
REQ-015 SHALL have port alu_fin  in  8  ALU result.
REQ-016 SHALL have ports alu_co, alu_cf  in  1 each  ALU carry-out and A>B flag.
REQ-017 SHALL have port done  out  1  one-cycle completion pulse.
REQ-018 SHALL have port result  out  8  last written-back result.
REQ-019 SHALL have ports flag_c, flag_z, flag_gt  out  1 each  carry, zero and greater flags.
REQ-020 SHALL have port dbg_sel  in  2  register select for readback.
REQ-021 SHALL have port dbg_data  out  8  combinational read of the selected register.

Function
REQ-022 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE.
REQ-023 SHALL assert instr_ready only in IDLE with ld_en low.
REQ-024 SHALL, on accept (IDLE, valid & ready), latch opcode and rd, register rf[rs1] into alu_a and rf[rs2] into alu_b, and enter EXEC.
REQ-025 SHALL drive alu_op from the latched opcode, with alu_ci = 1 only for opcode 001 and 0 otherwise; outputs are held stable for the whole of EXEC.
REQ-026 SHALL, on the EXEC->WB edge, capture alu_fin, alu_co and alu_cf.
REQ-027 SHALL, for opcodes 000/001, write rf[rd] and result from alu_fin, set flag_c = alu_co and set flag_z = (alu_fin == 0).
REQ-028 SHALL, for opcodes 010/011/100/110/111, write rf[rd] and result from alu_fin, set flag_z = (alu_fin == 0) and leave flag_c unchanged.
REQ-029 SHALL, for opcode 101 (compare), write no register, leave result and flag_z unchanged, and update only flag_gt.
REQ-030 SHALL set flag_gt = alu_cf (unsigned A>B) for every instruction.
REQ-031 SHALL assert done for exactly the WB cycle, i.e. 2 cycles after the accept edge, and then return to IDLE; throughput is one instruction per 3 cycles.
REQ-032 SHALL, in IDLE, load rf[ld_addr] = ld_data when ld_en is high; load has priority over instr_valid, and ld_en outside IDLE is ignored.
REQ-033 SHALL complete writeback before the next accept, so a following instruction reading rd sees the new value without stall.
REQ-034 SHALL treat rd == rs1 == rs2 as legal; operands are the pre-write values.

Reset
REQ-035 SHALL, while rst_n is low at a clock edge, go to IDLE and clear all registers, alu_a, alu_b, alu_op, alu_ci, result, all flags, done and instr_ready to 0.
REQ-036 SHALL abandon any in-flight instruction on reset, with no writeback and no done pulse.

Structure
REQ-037 SHALL take opcode localparams, state encoding and instr_data field positions from a shared package alu_seq_pkg.
REQ-038 SHALL place the 4x8 register file (2 read ports, 1 write port, dbg read port) in sub-module alu_regfile; the ALU is instantiated outside this block.

Verification
REQ-039 SHALL cover: load r1=0x0F, r2=0x01; ADD r0,r1,r2 -> done 2 cycles after accept, result 0x10, flag_c 0, flag_z 0, flag_gt 1, dbg r0 0x10.
REQ-040 SHALL cover: r1=0xFF, r2=0x01, ADD -> result 0x00, flag_c 1, flag_z 1.
REQ-041 SHALL cover: r1=r2=0x05, SUB r3,r2,r1 -> alu_ci 1 during EXEC, result 0x00, flag_z 1, flag_c 1.
REQ-042 SHALL cover: r1=0x80, r2=0x7F, opcode 101 -> rd unchanged, result unchanged, flag_gt 1.
REQ-043 SHALL cover: ld_en and instr_valid high together in IDLE -> load wins, instr_ready 0, and the instruction accepted next cycle uses the loaded value.
REQ-044 SHALL cover: rst_n low during EXEC -> no write to rd, no done, all outputs 0, IDLE after release.
